// File: rtl/interrupt_sequencer_pkg.sv
// mos6502_pkg: shared types and constants for the interrupt sequencer.
// Optional synchroniser depth applies when INTSEQ_SYNC_EN is defined.
package mos6502_pkg;

   localparam int SEQ_CYCLES     = 7;
   localparam int VEC_LOCK_CYCLE = 4;
   localparam int SYNC_STAGES    = 2;

   typedef enum logic [1:0] {
      KIND_RESET = 2'd0,
      KIND_NMI   = 2'd1,
      KIND_IRQ   = 2'd2,
      KIND_BRK   = 2'd3
   } int_kind_t;

   localparam logic [7:0] VEC_NMI_LO = 8'hFA;
   localparam logic [7:0] VEC_RST_LO = 8'hFC;
   localparam logic [7:0] VEC_IRQ_LO = 8'hFE;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PEND = 2'd1,
      ST_SEQ  = 2'd2
   } seq_state_t;

   function automatic logic [7:0] vector_of(int_kind_t k);
      case (k)
         KIND_RESET: return VEC_RST_LO;
         KIND_NMI:   return VEC_NMI_LO;
         default:    return VEC_IRQ_LO;
      endcase
   endfunction

endpackage

// File: rtl/interrupt_sequencer_if.sv
// Pin and decoder-facing bundle of the interrupt sequencer.
// slave = sequencer side, master = CPU/decoder side.
interface interrupt_sequencer_if;

   logic       NMI;
   logic       IRQ;
   logic       SO;
   logic       RDY;
   logic       SYNC;
   logic       I_FLAG;
   logic       BRK_OP;
   logic       FORCE_BRK;
   logic       SEQ_ACTIVE;
   logic [2:0] SEQ_STEP;
   logic [1:0] INT_KIND;
   logic [7:0] VECTOR_LO;
   logic       SUPPRESS_WR;
   logic       B_PUSH;
   logic       SET_V;
   logic       SEQ_DONE;

   modport slave (
      input  NMI, IRQ, SO, RDY, SYNC, I_FLAG, BRK_OP,
      output FORCE_BRK, SEQ_ACTIVE, SEQ_STEP, INT_KIND,
      output VECTOR_LO, SUPPRESS_WR, B_PUSH, SET_V, SEQ_DONE
   );

   modport master (
      output NMI, IRQ, SO, RDY, SYNC, I_FLAG, BRK_OP,
      input  FORCE_BRK, SEQ_ACTIVE, SEQ_STEP, INT_KIND,
      input  VECTOR_LO, SUPPRESS_WR, B_PUSH, SET_V, SEQ_DONE
   );

endinterface

// File: rtl/interrupt_sequencer_pin_conditioner.sv
// pin_conditioner: register chain plus falling-edge detect on the last tap.
// Chain is preloaded high so reset release never looks like an edge.
module pin_conditioner #(
   parameter int STAGES = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pin,
   output logic level,
   output logic fall
);

   logic [STAGES-1:0] q;
   logic [STAGES:0]   taps;

   assign taps  = {q, pin};
   assign level = taps[STAGES];
   assign fall  = taps[STAGES] & ~taps[STAGES-1];

   // shift the pin through the conditioning chain
   always_ff @(posedge clk) begin
      if (!rst_n) q <= '1;
      else        q <= taps[STAGES-1:0];
   end

endmodule

// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer: overrides opcode fetch and runs the 7-cycle entry.
// INTSEQ_SYNC_EN adds SYNC_STAGES synchroniser flops on NMI/IRQ/SO.
module interrupt_sequencer (
   input logic                  CLK,
   input logic                  RST_N,
   interrupt_sequencer_if.slave bus
);
   import mos6502_pkg::*;

`ifdef INTSEQ_SYNC_EN
   localparam int COND_STAGES = SYNC_STAGES + 1;
`else
   localparam int COND_STAGES = 1;
`endif
   localparam logic [2:0] LAST_STEP = 3'(SEQ_CYCLES - 1);
   localparam logic [2:0] LOCK_STEP = 3'(VEC_LOCK_CYCLE);

   seq_state_t state, state_nx;
   int_kind_t  kind, sel_kind;
   logic [2:0] step;
   logic [7:0] vec;
   logic       reset_pending, rst_pend_nx;
   logic       nmi_latch, nmi_latch_nx;
   logic       hijacked, set_v;
   logic       nmi_fall, so_fall, irq_level;
   logic       nmi_level_unused, so_level_unused, irq_fall_unused;
   logic       irq_req, hw_req, start, last, hijack_now, clr_nmi;

   pin_conditioner #(.STAGES(COND_STAGES)) u_nmi (
      .clk(CLK), .rst_n(RST_N), .pin(bus.NMI),
      .level(nmi_level_unused), .fall(nmi_fall)
   );

   pin_conditioner #(.STAGES(COND_STAGES)) u_irq (
      .clk(CLK), .rst_n(RST_N), .pin(bus.IRQ),
      .level(irq_level), .fall(irq_fall_unused)
   );

   pin_conditioner #(.STAGES(COND_STAGES)) u_so (
      .clk(CLK), .rst_n(RST_N), .pin(bus.SO),
      .level(so_level_unused), .fall(so_fall)
   );

   // request arbitration and source bookkeeping
   always_comb begin
      irq_req    = ~irq_level & ~bus.I_FLAG;
      hw_req     = reset_pending | nmi_latch | irq_req;
      start      = (state != ST_SEQ) & bus.SYNC & bus.RDY
                 & (hw_req | bus.BRK_OP);
      last       = (state == ST_SEQ) & (step == LAST_STEP) & bus.RDY;
      hijack_now = (state == ST_SEQ) & nmi_fall & (step < LOCK_STEP)
                 & ((kind == KIND_IRQ) | (kind == KIND_BRK));
      clr_nmi    = last & ((kind == KIND_NMI) | hijacked);
      nmi_latch_nx = nmi_fall | (nmi_latch & ~clr_nmi);
      rst_pend_nx  = reset_pending & ~(last & (kind == KIND_RESET));
      sel_kind = KIND_BRK;
      unique case (1'b1)
         reset_pending: sel_kind = KIND_RESET;
         nmi_latch:     sel_kind = KIND_NMI;
         irq_req:       sel_kind = KIND_IRQ;
         default:       sel_kind = KIND_BRK;
      endcase
   end

   // state register plus latched sequence context
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state         <= ST_IDLE;
         step          <= 3'd0;
         kind          <= KIND_RESET;
         vec           <= VEC_RST_LO;
         reset_pending <= 1'b1;
         nmi_latch     <= 1'b0;
         hijacked      <= 1'b0;
         set_v         <= 1'b0;
      end else begin
         state         <= state_nx;
         reset_pending <= rst_pend_nx;
         nmi_latch     <= nmi_latch_nx;
         set_v         <= so_fall;
         if (start) begin
            step     <= 3'd0;
            kind     <= sel_kind;
            vec      <= vector_of(sel_kind);
            hijacked <= 1'b0;
         end else if (state == ST_SEQ) begin
            if (hijack_now) begin
               vec      <= VEC_NMI_LO;
               hijacked <= 1'b1;
            end
            if (last)         step <= 3'd0;
            else if (bus.RDY) step <= step + 3'd1;
         end
      end
   end

   // next-state decision
   always_comb begin
      state_nx = state;
      unique case (state)
         ST_IDLE, ST_PEND: begin
            if (start)       state_nx = ST_SEQ;
            else if (hw_req) state_nx = ST_PEND;
            else             state_nx = ST_IDLE;
         end
         ST_SEQ: begin
            if (last)
               state_nx = (rst_pend_nx | nmi_latch_nx | irq_req)
                        ? ST_PEND : ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // decoder-facing outputs
   always_comb begin
      bus.FORCE_BRK   = RST_N & start & hw_req;
      bus.SEQ_ACTIVE  = (state == ST_SEQ);
      bus.SEQ_STEP    = step;
      bus.INT_KIND    = kind;
      bus.VECTOR_LO   = vec;
      bus.SUPPRESS_WR = (state == ST_SEQ) & (kind == KIND_RESET);
      bus.B_PUSH      = (state == ST_SEQ) & (kind == KIND_BRK);
      bus.SET_V       = set_v;
      bus.SEQ_DONE    = last;
   end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Scoreboard bench for interrupt_sequencer: directed scenarios push
// expected FORCE_BRK / SEQ_DONE / SET_V events, a monitor pops them.
module tb_interrupt_sequencer;

`ifdef INTSEQ_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif
   localparam int EV_FB   = 0;
   localparam int EV_DONE = 1;
   localparam int EV_SETV = 2;

   typedef struct {
      int et;
      int k;
      int v;
      int bp;
      int sw;
      int cyc;
   } ev_t;

   logic CLK = 1'b0;
   logic RST_N;
   int   cyc = 0;
   int   checks = 0;
   int   passed = 0;
   ev_t  exp_q[$];

   interrupt_sequencer_if bus();

   interrupt_sequencer dut (
      .CLK(CLK),
      .RST_N(RST_N),
      .bus(bus)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0h want %0h", name, act, exp);
   endtask

   task automatic push_ev(input int et, input int k, input int v,
                          input int bp, input int sw, input int c);
      ev_t e;
      e.et = et; e.k = k; e.v = v; e.bp = bp; e.sw = sw; e.cyc = c;
      exp_q.push_back(e);
   endtask

   task automatic observe(input int et);
      ev_t e;
      bit  ok;
      int  ak, av, abp, asw;
      ak  = int'(bus.INT_KIND);
      av  = int'(bus.VECTOR_LO);
      abp = int'(bus.B_PUSH);
      asw = int'(bus.SUPPRESS_WR);
      checks++;
      if (exp_q.size() == 0) begin
         $display("FAIL unexpected_event: got type %0d at cycle %0d, want none",
                  et, cyc);
         return;
      end
      e  = exp_q.pop_front();
      ok = (e.et == et) && (e.cyc == cyc);
      if (et == EV_DONE)
         ok = ok && (ak == e.k) && (av == e.v) && (abp == e.bp) && (asw == e.sw);
      if (ok) passed++;
      else $display({"FAIL event: got type %0d cyc %0d kind %0d vec %0h bp %0d sw %0d,",
                     " want type %0d cyc %0d kind %0d vec %0h bp %0d sw %0d"},
                    et, cyc, ak, av, abp, asw, e.et, e.cyc, e.k, e.v, e.bp, e.sw);
   endtask

   // monitor: flag overdue expectations, then match presented events
   always @(negedge CLK) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
         checks++;
         $display("FAIL missed_event: got none for type %0d by cycle %0d, want cycle %0d",
                  exp_q[0].et, cyc, exp_q[0].cyc);
         void'(exp_q.pop_front());
      end
      if (bus.FORCE_BRK === 1'b1) observe(EV_FB);
      if (bus.SEQ_DONE === 1'b1)  observe(EV_DONE);
      if (bus.SET_V === 1'b1)     observe(EV_SETV);
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // SYNC for one cycle; len=0 means the sequence is not expected to finish
   task automatic enter(input bit fb, input int k, input int v,
                        input int bp, input int sw, input int len);
      if (fb) push_ev(EV_FB, 0, 0, 0, 0, cyc);
      if (len > 0) push_ev(EV_DONE, k, v, bp, sw, cyc + len);
      bus.SYNC = 1'b1;
      tick();
      bus.SYNC = 1'b0;
   endtask

   task automatic sync_idle(input string name);
      bus.SYNC = 1'b1;
      tick();
      bus.SYNC = 1'b0;
      chk(name, int'(bus.SEQ_ACTIVE), 0);
   endtask

   task automatic check_reset();
      chk("rst_force_brk", int'(bus.FORCE_BRK), 0);
      chk("rst_seq_active", int'(bus.SEQ_ACTIVE), 0);
      chk("rst_seq_step", int'(bus.SEQ_STEP), 0);
      chk("rst_int_kind", int'(bus.INT_KIND), 0);
      chk("rst_vector_lo", int'(bus.VECTOR_LO), 'hFC);
      chk("rst_suppress_wr", int'(bus.SUPPRESS_WR), 0);
      chk("rst_b_push", int'(bus.B_PUSH), 0);
      chk("rst_set_v", int'(bus.SET_V), 0);
      chk("rst_seq_done", int'(bus.SEQ_DONE), 0);
   endtask

   initial begin
      RST_N      = 1'b0;
      bus.NMI    = 1'b1;
      bus.IRQ    = 1'b1;
      bus.SO     = 1'b1;
      bus.RDY    = 1'b1;
      bus.SYNC   = 1'b0;
      bus.I_FLAG = 1'b1;
      bus.BRK_OP = 1'b0;
      ticks(2);
      check_reset();

      // reset entry sequence
      RST_N = 1'b1;
      ticks(3);
      enter(1, 0, 'hFC, 0, 1, 7);
      chk("reset_active", int'(bus.SEQ_ACTIVE), 1);
      chk("reset_supwr", int'(bus.SUPPRESS_WR), 1);
      ticks(7);
      sync_idle("reset_serviced");

      // IRQ taken with I clear
      bus.IRQ = 1'b0;
      bus.I_FLAG = 1'b0;
      ticks(LAT + 1);
      enter(1, 2, 'hFE, 0, 0, 7);
      chk("irq_kind", int'(bus.INT_KIND), 2);
      chk("irq_bpush", int'(bus.B_PUSH), 0);
      bus.I_FLAG = 1'b1;
      ticks(7);
      sync_idle("irq_masked");
      bus.IRQ = 1'b1;
      ticks(LAT + 1);

      // BRK hijacked by NMI at step 2
      bus.BRK_OP = 1'b1;
      enter(0, 3, 'hFA, 1, 0, 7);
      bus.BRK_OP = 1'b0;
      ticks(2 - (LAT - 1));
      bus.NMI = 1'b0;
      ticks(LAT);
      bus.NMI = 1'b1;
      chk("hijack_vec", int'(bus.VECTOR_LO), 'hFA);
      chk("hijack_kind", int'(bus.INT_KIND), 3);
      chk("hijack_bpush", int'(bus.B_PUSH), 1);
      ticks(4);
      sync_idle("hijack_nmi_cleared");

      // NMI at step 5: BRK keeps vector, NMI follows
      bus.BRK_OP = 1'b1;
      enter(0, 3, 'hFE, 1, 0, 7);
      bus.BRK_OP = 1'b0;
      ticks(5 - (LAT - 1));
      bus.NMI = 1'b0;
      tick();
      bus.NMI = 1'b1;
      ticks(LAT);
      enter(1, 1, 'hFA, 0, 0, 7);
      ticks(7);
      sync_idle("late_nmi_serviced");

      // NMI held low: one sequence only
      bus.NMI = 1'b0;
      ticks(LAT + 1);
      enter(1, 1, 'hFA, 0, 0, 7);
      ticks(7);
      for (int i = 0; i < 10; i++) begin
         bus.SYNC = 1'b1;
         tick();
         bus.SYNC = 1'b0;
         ticks(3);
      end
      chk("nmi_held_idle", int'(bus.SEQ_ACTIVE), 0);
      bus.NMI = 1'b1;
      ticks(LAT + 1);

      // second NMI edge coincident with SEQ_DONE
      bus.NMI = 1'b0;
      tick();
      bus.NMI = 1'b1;
      ticks(LAT + 1);
      enter(1, 1, 'hFA, 0, 0, 7);
      ticks(6 - (LAT - 1));
      bus.NMI = 1'b0;
      tick();
      bus.NMI = 1'b1;
      ticks(LAT - 1);
      enter(1, 1, 'hFA, 0, 0, 7);
      ticks(7);
      sync_idle("double_nmi_done");

      // RDY stall at step 3
      bus.BRK_OP = 1'b1;
      enter(0, 3, 'hFE, 1, 0, 10);
      bus.BRK_OP = 1'b0;
      ticks(3);
      bus.RDY = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rdy_hold_step", int'(bus.SEQ_STEP), 3);
      end
      bus.RDY = 1'b1;
      ticks(4);

      // SO falling edge
      push_ev(EV_SETV, 0, 0, 0, 0, cyc + LAT);
      bus.SO = 1'b0;
      ticks(LAT + 3);
      bus.SO = 1'b1;
      ticks(LAT + 1);

      // reset mid-sequence at step 4
      bus.BRK_OP = 1'b1;
      enter(0, 3, 'hFE, 1, 0, 0);
      bus.BRK_OP = 1'b0;
      ticks(4);
      chk("pre_reset_step", int'(bus.SEQ_STEP), 4);
      RST_N = 1'b0;
      tick();
      check_reset();
      RST_N = 1'b1;
      tick();
      enter(1, 0, 'hFC, 0, 1, 7);
      ticks(9);

      chk("queue_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
- Sits directly upstream of the instruction decoder.
- Conditions the raw NMI, IRQ, SO and RDY pins and tracks the post-reset start-up.
- When an interrupt is due, it overrides the opcode fetch and sequences the 7-cycle interrupt/BRK/reset entry: force opcode 0x00, select the vector, choose the pushed B bit.
- The decoder consumes its outputs in place of the raw CPU pins.

Parameters:
- SEQ_CYCLES, 7: length of the interrupt entry sequence, in RDY-qualified cycles.
- VEC_LOCK_CYCLE, 4: sequence cycle at which the vector selection freezes (NMI hijack window closes).
- SYNC_STAGES, 2: synchroniser depth for asynchronous pins when INTSEQ_SYNC_EN is defined.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RST_N  in  1  synchronous, active-low reset.
- NMI  in  1  non-maskable interrupt, active-low, falling-edge sensitive.
- IRQ  in  1  maskable interrupt, active-low, level sensitive.
- SO  in  1  set-overflow pin, active-low, falling-edge sensitive.
- RDY  in  1  high = advance; low = freeze the sequence counter.
- SYNC  in  1  decoder is in its opcode-fetch cycle.
- I_FLAG  in  1  interrupt-disable bit of the processor status.
- BRK_OP  in  1  decoder fetched opcode 0x00 in the current SYNC cycle.
- FORCE_BRK  out  1  decoder substitutes 0x00 for the fetched opcode.
- SEQ_ACTIVE  out  1  entry sequence in progress.
- SEQ_STEP  out  3  current sequence cycle, 0..SEQ_CYCLES-1.
- INT_KIND  out  2  0=RESET, 1=NMI, 2=IRQ, 3=BRK.
- VECTOR_LO  out  8  low address byte of the vector: 0xFC RESET, 0xFA NMI, 0xFE IRQ/BRK.
- SUPPRESS_WR  out  1  reset sequence: stack pushes become reads.
- B_PUSH  out  1  value of the B bit pushed (1 only for BRK).
- SET_V  out  1  one-cycle pulse: set the V flag.
- SEQ_DONE  out  1  one-cycle pulse on the final sequence cycle.

Behaviour:
- Reset (RST_N=0 at clock edge), outputs:
  - FORCE_BRK=0, SEQ_ACTIVE=0, SEQ_STEP=0, INT_KIND=0, VECTOR_LO=0xFC, SUPPRESS_WR=0, B_PUSH=0, SET_V=0, SEQ_DONE=0.
- Reset, internal state:
  - NMI latch cleared.
  - Edge detectors preloaded to 1 (no false edge).
  - reset_pending=1.
- Reset asserted mid-sequence aborts the sequence immediately; state returns to IDLE.
- States:
  - IDLE: no request.
  - PEND: request latched, waiting for SYNC.
  - SEQ: entry in progress.
- Request sources, priority RESET > NMI > IRQ:
  - reset_pending.
  - nmi_latch: set on a 1->0 transition of conditioned NMI; stays set until serviced.
  - irq_req = (conditioned IRQ==0) & ~I_FLAG, evaluated live, never latched.
- IDLE->PEND when any request is true. PEND->IDLE if irq_req drops while no other request is true.
- PEND/IDLE->SEQ on a SYNC cycle with RDY=1 when a request is true or BRK_OP=1:
  - FORCE_BRK=1 for that cycle, except for BRK_OP.
  - INT_KIND and VECTOR_LO latched by priority; BRK_OP is used only if no hardware request is true.
- SEQ:
  - SEQ_STEP increments only when RDY=1 and holds when RDY=0.
  - SEQ_ACTIVE=1.
  - SUPPRESS_WR=1 iff INT_KIND=RESET.
  - B_PUSH=1 iff INT_KIND=BRK.
- NMI hijack: if nmi_latch sets while SEQ_STEP < VEC_LOCK_CYCLE and INT_KIND is IRQ or BRK:
  - VECTOR_LO switches to 0xFA.
  - INT_KIND and B_PUSH are unchanged; the NMI counts as serviced.
- At SEQ_STEP=SEQ_CYCLES-1 with RDY=1:
  - SEQ_DONE pulses.
  - The serviced source is cleared: reset_pending, or nmi_latch (nmi_latch is also cleared for a hijack).
  - Next state is PEND if another request is true, else IDLE.
- Simultaneous NMI edge and clear: a new edge in the same cycle as SEQ_DONE wins; nmi_latch stays set.
- SET_V pulses one cycle after each conditioned SO falling edge, independent of state and RDY.
- Counter never wraps: SEQ_STEP stays below SEQ_CYCLES.

Optional Feature:
- Macro INTSEQ_SYNC_EN.
- Defined: NMI, IRQ and SO pass through SYNC_STAGES-flop synchronisers before edge/level detection; latency pin->latch is SYNC_STAGES+1 cycles.
- Undefined: a single register stage only; latency pin->latch is 1 cycle. Used for synchronous simulation.

Decomposition:
- Package mos6502_pkg:
  - int_kind_t enum (RESET, NMI, IRQ, BRK).
  - Vector constants VEC_NMI_LO=0xFA, VEC_RST_LO=0xFC, VEC_IRQ_LO=0xFE.
  - Sequencer state enum.
- One sub-module, pin_conditioner: synchroniser plus falling-edge detector, instantiated for NMI and SO; the IRQ instance uses its level output only.

Test Plan:
- Release RST_N, SYNC pulse at cycle 3 -> FORCE_BRK=1, INT_KIND=0, VECTOR_LO=0xFC, SUPPRESS_WR=1 for 7 cycles, SEQ_DONE at step 6, then IDLE.
- IRQ=0, I_FLAG=0, SYNC -> INT_KIND=2, VECTOR_LO=0xFE, B_PUSH=0. Repeat with I_FLAG=1 -> stays IDLE, no FORCE_BRK.
- BRK_OP=1 on SYNC, NMI falls at step 2 -> VECTOR_LO becomes 0xFA, INT_KIND=3, B_PUSH=1; after SEQ_DONE, nmi_latch is clear. NMI at step 5 -> vector stays 0xFE, NMI serviced afterwards.
- NMI held low for 50 cycles -> exactly one NMI sequence. NMI pulsed twice, second edge coincident with SEQ_DONE -> a second sequence follows.
- RDY=0 for 3 cycles at step 3 -> SEQ_STEP holds at 3, total sequence is 10 cycles, SEQ_DONE fires once.
- SO falls -> SET_V single-cycle pulse after 1 cycle (macro undefined) or 3 cycles (defined). RST_N=0 at step 4 -> all outputs return to reset values on the next edge.
